soc_system_fpga_dsp_byte_tx: RTL

Avalon-MM slave that carries bytes from the HPS to the DSP fabric logic, the outbound counterpart of the DSP byte input port. HPS writes are pushed into a small FIFO. The FIFO head is presented on `out_port` with a valid/ready handshake toward the DSP consumer. Status, control and sticky-overflow registers are readable over the same lightweight-bridge slave.

---
 rtl/soc_system_fpga_dsp_byte_tx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/soc_system_fpga_dsp_byte_tx.sv
// -----------------------------------------------------------------------------
// soc_system_fpga_dsp_byte_tx
//
// Avalon-MM slave that forwards bytes from the HPS to the DSP fabric. Each
// write to address 0 is queued in a small FIFO. The FIFO head is offered to the
// DSP consumer with a valid/ready handshake.
//
// Register map (readdata is registered and reloaded every cycle):
//   0  W: push writedata[7:0]    R: current out_port, zero-extended
//   1  R: {16'h0, occupancy[7:0], 5'h0, overflow, full, empty}
//   2  RW: bit0 enable, bit1 flush (write-1 action, reads 0), bit2 irq_en
//   3  W: any write clears overflow   R: 0
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   address      register select
//   chipselect   slave select
//   write_n      active-low write strobe, qualified by chipselect
//   writedata    write data
//   readdata     registered read data
//   out_port     byte toward the DSP logic
//   out_valid    out_port holds an unconsumed byte
//   out_ready    DSP consumer accepts the byte this cycle
//   irq          FIFO-empty interrupt (only with DSP_BYTE_TX_IRQ_EN)
//
// Build option:
//   DSP_BYTE_TX_IRQ_EN  adds the irq port and the irq_en control bit. Without
//                       it, control bit 2 reads 0 and ignores writes.
// -----------------------------------------------------------------------------
module soc_system_fpga_dsp_byte_tx #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  out_port,
   output logic        out_valid,
   input  logic        out_ready
`ifdef DSP_BYTE_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               enable_q, enable_d;
   logic               overflow_q, overflow_d;
   logic [7:0]         hold_q, hold_d;
   logic [31:0]        readdata_q, readdata_d;

   logic               wr_stb, wr_data, wr_ctrl, wr_clr;
   logic               flush, push, pop;
   logic               empty, full;
   logic [7:0]         head;
   logic [7:0]         occ;
   logic               irq_en_bit;
   logic               unused_wdata;

   assign unused_wdata = ^writedata[31:8];

   assign wr_stb  = chipselect && !write_n;
   assign wr_data = wr_stb && (address == 2'd0);
   assign wr_ctrl = wr_stb && (address == 2'd2);
   assign wr_clr  = wr_stb && (address == 2'd3);
   assign flush   = wr_ctrl && writedata[1];

   assign empty   = (level_q == '0);
   assign full    = (level_q == LEVEL_W'(FIFO_DEPTH));
   assign head    = mem_q[rd_ptr_q];

   assign out_valid = enable_q && !empty;
   assign pop       = out_valid && out_ready;
   // Between transfers the port keeps showing the last byte consumed.
   assign out_port  = out_valid ? head : hold_q;

   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   // Flush discards any concurrent push.
   assign push = wr_data && !flush && (!full || pop);

   assign occ = 8'(level_q);

`ifdef DSP_BYTE_TX_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q;

   assign irq_en_bit = irq_en_q;
   assign irq        = irq_q;

   always_comb begin
      irq_en_d = irq_en_q;
      if (wr_ctrl) begin
         irq_en_d = writedata[2];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_en_q && empty;
      end
   end
`else
   assign irq_en_bit = 1'b0;
`endif

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      enable_d   = enable_q;
      overflow_d = overflow_q;
      hold_d     = hold_q;
      readdata_d = 32'h0;

      if (pop) begin
         hold_d = head;
      end

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
         endcase
      end

      if (wr_data && full && !pop && !flush) begin
         overflow_d = 1'b1;
      end
      if (wr_clr) begin
         overflow_d = 1'b0;
      end

      if (wr_ctrl) begin
         enable_d = writedata[0];
      end

      case (address)
         2'd0:    readdata_d = {24'h0, out_port};
         2'd1:    readdata_d = {16'h0, occ, 5'h0, overflow_q, full, empty};
         2'd2:    readdata_d = {29'h0, irq_en_bit, 1'b0, enable_q};
         default: readdata_d = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         enable_q   <= 1'b0;
         overflow_q <= 1'b0;
         hold_q     <= 8'h00;
         readdata_q <= 32'h0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         enable_q   <= enable_d;
         overflow_q <= overflow_d;
         hold_q     <= hold_d;
         readdata_q <= readdata_d;
      end
   end

   // Storage needs no reset: nothing is visible until a push fills a slot.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= writedata[7:0];
      end
   end

   assign readdata = readdata_q;

endmodule
